// File: rtl/msg_pkg.sv
// Shared types, ASCII constants and small helpers for the message scheduler.
package msg_pkg;

   // Message types, also used as slot index and as grant_id encoding.
   typedef enum logic [1:0] {
      MSG_FAULT   = 2'd0,
      MSG_PICKUP  = 2'd1,
      MSG_DEPOSIT = 2'd2,
      MSG_END     = 2'd3
   } msg_type_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Payload captured with each request.
   typedef struct packed {
      logic [1:0] unit;
      logic [1:0] su;
      logic [1:0] blk;
   } payload_t;

   localparam logic [7:0] ASC_HASH  = 8'h23;
   localparam logic [7:0] ASC_DASH  = 8'h2D;
   localparam logic [7:0] ASC_ONE   = 8'h31;
   localparam logic [7:0] ASC_QMARK = 8'h3F;
   localparam logic [7:0] ASC_B     = 8'h42;
   localparam logic [7:0] ASC_C     = 8'h43;
   localparam logic [7:0] ASC_D     = 8'h44;
   localparam logic [7:0] ASC_E     = 8'h45;
   localparam logic [7:0] ASC_F     = 8'h46;
   localparam logic [7:0] ASC_I     = 8'h49;
   localparam logic [7:0] ASC_M     = 8'h4D;
   localparam logic [7:0] ASC_N     = 8'h4E;
   localparam logic [7:0] ASC_P     = 8'h50;
   localparam logic [7:0] ASC_R     = 8'h52;
   localparam logic [7:0] ASC_S     = 8'h53;
   localparam logic [7:0] ASC_U     = 8'h55;

   // unit_code -> letter; code 3 has no unit and shows as '?'.
   function automatic logic [7:0] unit_letter(input logic [1:0] code);
      case (code)
         2'd0:    return ASC_E;
         2'd1:    return ASC_C;
         2'd2:    return ASC_R;
         default: return ASC_QMARK;
      endcase
   endfunction

   // 0..3 -> ASCII '1'..'4'.
   function automatic logic [7:0] id_digit(input logic [1:0] code);
      return ASC_ONE + {6'd0, code};
   endfunction

   // Round-robin successor among FAULT/PICKUP/DEPOSIT.
   function automatic msg_type_e rr_next(input msg_type_e t);
      case (t)
         MSG_FAULT:  return MSG_PICKUP;
         MSG_PICKUP: return MSG_DEPOSIT;
         default:    return MSG_FAULT;
      endcase
   endfunction

endpackage

// File: rtl/msg_tx_scheduler_if.sv
// Byte stream handshake towards the UART transmitter.
interface msg_tx_scheduler_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/msg_char_rom.sv
// Combinational character generator: (type, idx, payload) -> ASCII byte.
module msg_char_rom
   import msg_pkg::*;
(
   input  msg_type_e  msg_type,
   input  logic [3:0] idx,
   input  payload_t   payload,
   output logic [7:0] char_out
);

   // Out-of-range indices return '#' so a stream always terminates.
   always_comb begin
      char_out = ASC_HASH;
      if (msg_type == MSG_END) begin
         case (idx)
            4'd0:    char_out = ASC_E;
            4'd1:    char_out = ASC_N;
            4'd2:    char_out = ASC_D;
            4'd3:    char_out = ASC_DASH;
            default: char_out = ASC_HASH;
         endcase
      end else begin
         case (idx)
            4'd0:    char_out = (msg_type == MSG_FAULT) ? ASC_F : ASC_B;
            4'd1:    char_out = (msg_type == MSG_FAULT)  ? ASC_I :
                                (msg_type == MSG_PICKUP) ? ASC_P : ASC_D;
            4'd2:    char_out = ASC_M;
            4'd3:    char_out = ASC_DASH;
            4'd4:    char_out = unit_letter(payload.unit);
            4'd5:    char_out = ASC_S;
            4'd6:    char_out = ASC_U;
            4'd7:    char_out = id_digit(payload.su);
            4'd8:    char_out = ASC_DASH;
            4'd9:    char_out = (msg_type == MSG_FAULT) ? ASC_HASH : ASC_B;
            4'd10:   char_out = id_digit(payload.blk);
            4'd11:   char_out = ASC_DASH;
            default: char_out = ASC_HASH;
         endcase
      end
   end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Message request slots, arbitration and paced byte streaming into uart_tx.
module msg_tx_scheduler
   import msg_pkg::*;
#(
   parameter logic [15:0] GAP_CYCLES = 16'd4340
)
(
   input  logic                      clk_50M,
   input  logic                      reset,
   input  logic                      req_fault,
   input  logic                      req_pickup,
   input  logic                      req_deposit,
   input  logic                      req_end,
   input  logic [1:0]                unit_code,
   input  logic [1:0]                su_id,
   input  logic [1:0]                blk_id,
   msg_tx_scheduler_if.master        tx,
   output logic                      busy,
   output logic [1:0]                grant_id,
   output logic                      msg_done,
   output logic                      drop_err,
   output logic                      run_ended
);

   state_e     state_reg, state_next;
   msg_type_e  type_reg, ptr_reg;
   msg_type_e  cand0, cand1, cand2, win;
   logic [1:0] win_code;
   payload_t   pay_reg, req_pay;
   payload_t   slot_pay_reg  [4];
   payload_t   slot_pay_next [4];
   logic [3:0] pend_reg, pend_next;
   logic [3:0] req_vec, clear_vec, drop_vec, take_vec;
   logic [3:0] idx_reg;
   logic [15:0] gap_cnt_reg;
   logic       last_reg;
   logic       drop_err_reg;
   logic [7:0] char_byte;
   logic       tx_valid_c, hs, is_hash, capture_ok;

   assign req_vec    = {req_end, req_deposit, req_pickup, req_fault};
   assign req_pay    = {unit_code, su_id, blk_id};
   assign capture_ok = (state_reg != ST_DONE);

   msg_char_rom u_rom (
      .msg_type (type_reg),
      .idx      (idx_reg),
      .payload  (pay_reg),
      .char_out (char_byte)
   );

   assign is_hash = (char_byte == ASC_HASH);
   assign hs      = tx_valid_c && tx.tx_ready;

   // Winner: END always first, otherwise first pending type from the RR pointer.
   assign cand0 = ptr_reg;
   assign cand1 = rr_next(cand0);
   assign cand2 = rr_next(cand1);
   always_comb begin
      win = cand2;
      if (pend_reg[MSG_END])
         win = MSG_END;
      else if (pend_reg[cand0])
         win = cand0;
      else if (pend_reg[cand1])
         win = cand1;
   end
   assign win_code = win;

   // Per-slot capture/clear; a req hitting the slot being cleared in LOAD refills it.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         assign clear_vec[gi]     = (state_reg == ST_LOAD) && (win_code == 2'(gi));
         assign drop_vec[gi]      = capture_ok && req_vec[gi] && pend_reg[gi] && !clear_vec[gi];
         assign take_vec[gi]      = capture_ok && req_vec[gi] && !drop_vec[gi];
         assign pend_next[gi]     = take_vec[gi] | (pend_reg[gi] & ~clear_vec[gi]);
         assign slot_pay_next[gi] = take_vec[gi] ? req_pay : slot_pay_reg[gi];
      end
   endgenerate

   // Slot storage and sticky drop flag.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         pend_reg     <= '0;
         drop_err_reg <= 1'b0;
         for (int i = 0; i < 4; i++)
            slot_pay_reg[i] <= '0;
      end else begin
         pend_reg     <= pend_next;
         drop_err_reg <= drop_err_reg | (|drop_vec);
         for (int i = 0; i < 4; i++)
            slot_pay_reg[i] <= slot_pay_next[i];
      end
   end

   // FSM state register.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      tx_valid_c = 1'b0;
      busy       = 1'b0;
      msg_done   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|pend_reg)
               state_next = ST_LOAD;
         end
         ST_LOAD: begin
            busy       = 1'b1;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            busy       = 1'b1;
            tx_valid_c = 1'b1;
            if (tx.tx_ready) begin
               if (is_hash) begin
                  msg_done = 1'b1;
                  if (type_reg == MSG_END)
                     state_next = ST_DONE;
                  else if (GAP_CYCLES == 16'd0)
                     state_next = ST_IDLE;
                  else
                     state_next = ST_GAP;
               end else if (GAP_CYCLES != 16'd0) begin
                  state_next = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            busy = 1'b1;
            if (gap_cnt_reg == GAP_CYCLES - 16'd1)
               state_next = last_reg ? ST_IDLE : ST_SEND;
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Message datapath: latch winner in LOAD, advance index on handshake, pace in GAP.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         type_reg    <= MSG_FAULT;
         ptr_reg     <= MSG_FAULT;
         pay_reg     <= '0;
         idx_reg     <= '0;
         gap_cnt_reg <= '0;
         last_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_LOAD: begin
               type_reg <= win;
               pay_reg  <= slot_pay_reg[win];
               idx_reg  <= '0;
               last_reg <= 1'b0;
               if (win != MSG_END)
                  ptr_reg <= rr_next(win);
            end
            ST_SEND: begin
               gap_cnt_reg <= '0;
               if (hs) begin
                  idx_reg  <= idx_reg + 4'd1;
                  last_reg <= is_hash;
               end
            end
            ST_GAP: begin
               gap_cnt_reg <= gap_cnt_reg + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign tx.tx_valid = tx_valid_c;
   assign tx.tx_data  = tx_valid_c ? char_byte : 8'h00;
   assign grant_id    = type_reg;
   assign drop_err    = drop_err_reg;
   assign run_ended   = (state_reg == ST_DONE);

endmodule
